// File: rtl/kyber_pkg.sv
// kyber_pkg: shared word width, Kyber1024 ciphertext length and FSM state type
package kyber_pkg;
   localparam int KYBER_DW = 32;
   localparam int KYBER1024_CT_WORDS = 392;
   typedef enum logic [1:0] {IDLE, CAPTURE, READY} ct_fifo_state_t;
endpackage

// File: rtl/kyber_ct_fifo_if.sv
// kyber_ct_fifo_if: ciphertext FIFO bundle
//   master (core/bus side): drives start, in_valid, in_data, rd_en
//   slave (FIFO): drives in_ready, rd_data, rd_valid, count, empty, full, ct_done, err
//   csum present only with KYBER_CT_FIFO_CSUM_EN
interface kyber_ct_fifo_if import kyber_pkg::*; #(
   parameter int DW = KYBER_DW,
   parameter int DEPTH = 512
);
   logic start, in_valid, in_ready, rd_en, rd_valid, empty, full, ct_done;
   logic [DW-1:0] in_data, rd_data;
   logic [$clog2(DEPTH+1)-1:0] count;
   logic [1:0] err;
`ifdef KYBER_CT_FIFO_CSUM_EN
   logic [DW-1:0] csum;
`endif
   modport master(
      output start, in_valid, in_data, rd_en,
      input in_ready, rd_data, rd_valid, count, empty, full, ct_done, err
`ifdef KYBER_CT_FIFO_CSUM_EN
      , csum
`endif
   );
   modport slave(
      input start, in_valid, in_data, rd_en,
      output in_ready, rd_data, rd_valid, count, empty, full, ct_done, err
`ifdef KYBER_CT_FIFO_CSUM_EN
      , csum
`endif
   );
endinterface

// File: rtl/kyber_ct_ram.sv
// kyber_ct_ram: simple dual-port DEPTH x DW storage with synchronous read
//   clk; we/wa/wd write port; re/ra read port; rq registered read data (holds when re low)
module kyber_ct_ram #(
   parameter int DW = 32,
   parameter int DEPTH = 512,
   localparam int AW = $clog2(DEPTH)
) (
   input logic clk,
   input logic we,
   input logic [AW-1:0] wa,
   input logic [DW-1:0] wd,
   input logic re,
   input logic [AW-1:0] ra,
   output logic [DW-1:0] rq
);
   logic [DW-1:0] mem [DEPTH];
   always_ff @(posedge clk) begin
      if (we) mem[wa] <= wd;
      if (re) rq <= mem[ra];
   end
endmodule

// File: rtl/kyber_ct_fifo.sv
// kyber_ct_fifo: captures one Kyber ciphertext from the core and buffers it for bus reads
//   clk, rst (async, active high); b: kyber_ct_fifo_if.slave
//   optional running XOR checksum on b.csum with KYBER_CT_FIFO_CSUM_EN
module kyber_ct_fifo import kyber_pkg::*; #(
   parameter int DW = KYBER_DW,
   parameter int DEPTH = 512,
   parameter int CT_WORDS = KYBER1024_CT_WORDS
) (
   input logic clk,
   input logic rst,
   kyber_ct_fifo_if.slave b
);
   localparam int AW = $clog2(DEPTH);
   localparam int CW = $clog2(DEPTH+1);
   localparam int NW = $clog2(CT_WORDS+1);
   ct_fifo_state_t state, state_n;
   logic [AW-1:0] wp, rp;
   logic [CW-1:0] cnt;
   logic [NW-1:0] ncap;
   logic [DW-1:0] rq;
   logic wr, rd, last_wr, popped;
   assign b.count = cnt;
   assign b.empty = cnt == '0;
   assign b.full = cnt == CW'(DEPTH);
   // start flushes, so it wins over a coincident write or pop
   assign wr = b.in_valid && b.in_ready && !b.start;
   assign rd = b.rd_en && !b.empty && !b.start;
   assign last_wr = wr && ncap == NW'(CT_WORDS - 1);
   // RAM output is unreset; show zero until the first pop after reset
   assign b.rd_data = popped ? rq : '0;
   always_ff @(posedge clk or posedge rst)
      if (rst) state <= IDLE;
      else state <= state_n;
   always_comb
      state_n = b.start ? CAPTURE :
                (state == CAPTURE && last_wr) ? READY :
                (state == READY && rd && cnt == CW'(1)) ? IDLE : state;
   always_comb
      b.in_ready = state == CAPTURE && !b.full;
   always_ff @(posedge clk or posedge rst)
      if (rst) begin
         wp <= '0;
         rp <= '0;
         cnt <= '0;
         ncap <= '0;
         b.ct_done <= 1'b0;
         b.err <= '0;
         b.rd_valid <= 1'b0;
         popped <= 1'b0;
      end else begin
         wp <= b.start ? '0 : wp + AW'(wr);
         rp <= b.start ? '0 : rp + AW'(rd);
         cnt <= b.start ? '0 : cnt + CW'(wr) - CW'(rd);
         ncap <= b.start ? '0 : ncap + NW'(wr);
         b.ct_done <= !b.start && (b.ct_done || last_wr);
         b.err <= b.start ? '0 : b.err | {b.rd_en && b.empty, b.in_valid && !b.in_ready};
         b.rd_valid <= rd;
         popped <= popped || rd;
      end
`ifdef KYBER_CT_FIFO_CSUM_EN
   always_ff @(posedge clk or posedge rst)
      if (rst) b.csum <= '0;
      else b.csum <= b.start ? '0 : wr ? b.csum ^ b.in_data : b.csum;
`endif
   kyber_ct_ram #(.DW(DW), .DEPTH(DEPTH)) u_ram (
      .clk(clk),
      .we(wr),
      .wa(wp),
      .wd(b.in_data),
      .re(rd),
      .ra(rp),
      .rq(rq)
   );
endmodule

// File: tb/tb_kyber_ct_fifo.sv
// tb_kyber_ct_fifo: directed checks of the ciphertext FIFO at full size and at DEPTH=8/CT_WORDS=20
module tb_kyber_ct_fifo;
   import kyber_pkg::*;
   logic clk = 1'b0;
   logic rst = 1'b0;
   int total = 0;
   int bad = 0;
   logic [31:0] x;
   always #5 clk = ~clk;
   kyber_ct_fifo_if #(.DW(32), .DEPTH(512)) bi ();
   kyber_ct_fifo_if #(.DW(32), .DEPTH(8)) si ();
   kyber_ct_fifo #(.DW(32), .DEPTH(512), .CT_WORDS(392)) u_big (.clk(clk), .rst(rst), .b(bi));
   kyber_ct_fifo #(.DW(32), .DEPTH(8), .CT_WORDS(20)) u_small (.clk(clk), .rst(rst), .b(si));
   task automatic tick;
      @(posedge clk);
      #1;
   endtask
   task automatic chk(input string t, input logic [63:0] o, input logic [63:0] e);
      total++;
      assert (o === e) else begin
         bad++;
         $error("FAIL %s observed=%0h expected=%0h", t, o, e);
      end
   endtask
   initial begin
      {bi.start, bi.in_valid, bi.rd_en, si.start, si.in_valid, si.rd_en} = '0;
      bi.in_data = '0;
      si.in_data = '0;
      #2 rst = 1'b1;
      #1;
      chk("rst_count", bi.count, 0);
      chk("rst_empty", bi.empty, 1);
      chk("rst_full", bi.full, 0);
      chk("rst_in_ready", bi.in_ready, 0);
      chk("rst_rd_valid", bi.rd_valid, 0);
      chk("rst_rd_data", bi.rd_data, 0);
      chk("rst_ct_done", bi.ct_done, 0);
      chk("rst_err", bi.err, 0);
      chk("rst_state", u_big.state, IDLE);
      tick;
      rst = 1'b0;
      bi.in_valid = 1'b1;
      bi.in_data = 32'hAA;
      tick;
      bi.in_valid = 1'b0;
      chk("idle_drop_err", bi.err, 2'b01);
      chk("idle_drop_count", bi.count, 0);
      bi.rd_en = 1'b1;
      tick;
      bi.rd_en = 1'b0;
      chk("underflow_err", bi.err, 2'b11);
      chk("underflow_rd_valid", bi.rd_valid, 0);
      bi.start = 1'b1;
      tick;
      bi.start = 1'b0;
      chk("start_err", bi.err, 0);
      chk("start_in_ready", bi.in_ready, 1);
      chk("start_state", u_big.state, CAPTURE);
      x = '0;
      for (int i = 0; i < 392; i++) begin
         bi.in_valid = 1'b1;
         bi.in_data = 32'(i);
         x ^= 32'(i);
         tick;
         if (i == 390) chk("ct_done_early", bi.ct_done, 0);
      end
      bi.in_valid = 1'b0;
      chk("cap_count", bi.count, 392);
      chk("cap_ct_done", bi.ct_done, 1);
      chk("cap_in_ready", bi.in_ready, 0);
      chk("cap_err", bi.err, 0);
      chk("cap_full", bi.full, 0);
      chk("cap_state", u_big.state, READY);
`ifdef KYBER_CT_FIFO_CSUM_EN
      chk("csum", bi.csum, x);
`endif
      bi.in_valid = 1'b1;
      bi.in_data = 32'd999;
      tick;
      bi.in_valid = 1'b0;
      chk("extra_err", bi.err, 2'b01);
      chk("extra_count", bi.count, 392);
      for (int k = 0; k < 392; k++) begin
         bi.rd_en = 1'b1;
         tick;
         chk("drain_valid", bi.rd_valid, 1);
         chk("drain_data", bi.rd_data, k);
      end
      bi.rd_en = 1'b0;
      chk("drain_empty", bi.empty, 1);
      chk("drain_state", u_big.state, IDLE);
      tick;
      chk("drain_rd_valid_low", bi.rd_valid, 0);
      chk("drain_rd_data_hold", bi.rd_data, 391);
      chk("drain_err", bi.err, 2'b01);
      bi.start = 1'b1;
      tick;
      bi.start = 1'b0;
      for (int i = 0; i < 50; i++) begin
         bi.in_valid = 1'b1;
         bi.in_data = 32'(i);
         tick;
      end
      bi.in_valid = 1'b0;
      chk("part_count", bi.count, 50);
      bi.start = 1'b1;
      bi.in_valid = 1'b1;
      bi.in_data = 32'hDEAD;
      tick;
      bi.start = 1'b0;
      bi.in_valid = 1'b0;
      chk("restart_count", bi.count, 0);
      chk("restart_ct_done", bi.ct_done, 0);
      chk("restart_err", bi.err, 0);
      chk("restart_state", u_big.state, CAPTURE);
      for (int i = 0; i < 392; i++) begin
         bi.in_valid = 1'b1;
         bi.in_data = 32'(i + 1000);
         tick;
      end
      bi.in_valid = 1'b0;
      chk("recap_count", bi.count, 392);
      chk("recap_ct_done", bi.ct_done, 1);
      chk("recap_err", bi.err, 0);
      bi.rd_en = 1'b1;
      tick;
      bi.rd_en = 1'b0;
      chk("recap_first", bi.rd_data, 1000);
      bi.start = 1'b1;
      tick;
      bi.start = 1'b0;
      for (int i = 0; i < 100; i++) begin
         bi.in_valid = 1'b1;
         bi.in_data = 32'(i + 5);
         tick;
      end
      bi.in_valid = 1'b0;
      #2 rst = 1'b1;
      #1;
      chk("mid_rst_count", bi.count, 0);
      chk("mid_rst_empty", bi.empty, 1);
      chk("mid_rst_in_ready", bi.in_ready, 0);
      chk("mid_rst_rd_data", bi.rd_data, 0);
      chk("mid_rst_rd_valid", bi.rd_valid, 0);
      chk("mid_rst_ct_done", bi.ct_done, 0);
      chk("mid_rst_err", bi.err, 0);
      chk("mid_rst_state", u_big.state, IDLE);
      tick;
      rst = 1'b0;
      bi.start = 1'b1;
      tick;
      bi.start = 1'b0;
      bi.in_valid = 1'b1;
      bi.in_data = 32'd77;
      tick;
      bi.in_valid = 1'b0;
      chk("post_rst_count", bi.count, 1);
      bi.rd_en = 1'b1;
      tick;
      bi.rd_en = 1'b0;
      chk("post_rst_data", bi.rd_data, 77);
      chk("post_rst_empty", bi.empty, 1);
      si.start = 1'b1;
      tick;
      si.start = 1'b0;
      for (int i = 0; i < 8; i++) begin
         si.in_valid = 1'b1;
         si.in_data = 32'(i);
         tick;
         if (i == 6) chk("s_not_full", si.full, 0);
      end
      chk("s_full", si.full, 1);
      chk("s_full_in_ready", si.in_ready, 0);
      chk("s_full_count", si.count, 8);
      tick;
      si.in_valid = 1'b0;
      chk("s_full_drop_err", si.err, 2'b01);
      chk("s_full_drop_count", si.count, 8);
      si.start = 1'b1;
      tick;
      si.start = 1'b0;
      chk("s_restart_err", si.err, 0);
      for (int i = 0; i < 4; i++) begin
         si.in_valid = 1'b1;
         si.in_data = 32'(i);
         tick;
      end
      chk("s_pre_count", si.count, 4);
      for (int j = 4; j < 20; j++) begin
         si.in_valid = 1'b1;
         si.in_data = 32'(j);
         si.rd_en = 1'b1;
         tick;
         chk("s_ovl_count", si.count, 4);
         chk("s_ovl_valid", si.rd_valid, 1);
         chk("s_ovl_data", si.rd_data, j - 4);
      end
      si.in_valid = 1'b0;
      si.rd_en = 1'b0;
      chk("s_ovl_state", u_small.state, READY);
      chk("s_ovl_ct_done", si.ct_done, 1);
      chk("s_ovl_in_ready", si.in_ready, 0);
      for (int k = 0; k < 4; k++) begin
         si.rd_en = 1'b1;
         tick;
         chk("s_tail_data", si.rd_data, 16 + k);
      end
      si.rd_en = 1'b0;
      chk("s_tail_state", u_small.state, IDLE);
      chk("s_tail_empty", si.empty, 1);
      chk("s_tail_err", si.err, 0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
